// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, writeback, issue and scoreboard status.
// The slave side is the register file; the master side is the decode/writeback logic.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              flush;
    logic              rs_busy;
    logic              rt_busy;
    logic              stall;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output rs_addr, rt_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rs_data, rt_data, rs_busy, rt_busy, stall, pend_cnt
    );

    modport slave (
        input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rs_data, rt_data, rs_busy, rt_busy, stall, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write bypass and a per-register pending
// scoreboard that flags RAW/WAW hazards and keeps a running count of pending registers.
module regfile_scoreboard #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;

    logic rs_zero, rt_zero, wr_zero, iss_zero;
    logic rs_hit, rt_hit;
    logic rs_busy, rt_busy, waw, stall;
    logic iss_ok, inc, dec;

    assign rs_zero  = ZERO_R0 && (bus.rs_addr == '0);
    assign rt_zero  = ZERO_R0 && (bus.rt_addr == '0);
    assign wr_zero  = ZERO_R0 && (bus.wr_addr == '0);
    assign iss_zero = ZERO_R0 && (bus.iss_addr == '0);
    assign rs_hit   = BYPASS && bus.wr_en && (bus.wr_addr == bus.rs_addr);
    assign rt_hit   = BYPASS && bus.wr_en && (bus.wr_addr == bus.rt_addr);

    always_comb begin
        bus.rs_data = mem[bus.rs_addr];
        if (rs_hit)  bus.rs_data = bus.wr_data;
        if (rs_zero) bus.rs_data = '0;
        bus.rt_data = mem[bus.rt_addr];
        if (rt_hit)  bus.rt_data = bus.wr_data;
        if (rt_zero) bus.rt_data = '0;
    end

    assign rs_busy = pending[bus.rs_addr] && !rs_hit && !rs_zero;
    assign rt_busy = pending[bus.rt_addr] && !rt_hit && !rt_zero;
    // A writeback landing on the issue target retires the old producer, so no WAW stall.
    assign waw     = bus.iss_en && pending[bus.iss_addr]
                     && !(bus.wr_en && (bus.wr_addr == bus.iss_addr));
    assign stall   = rs_busy | rt_busy | waw;
    assign iss_ok  = bus.iss_en && !stall && !iss_zero;

    assign bus.rs_busy  = rs_busy;
    assign bus.rt_busy  = rt_busy;
    assign bus.stall    = stall;
    assign bus.pend_cnt = cnt;

    always_comb begin
        pend_nxt = pending;
        if (bus.flush) begin
            pend_nxt = '0;
        end else begin
            if (bus.wr_en) pend_nxt[bus.wr_addr] = 1'b0;
            if (iss_ok)    pend_nxt[bus.iss_addr] = 1'b1;
        end
    end

    // Count tracks the popcount: an issue re-arming the register being cleared nets zero.
    assign inc = iss_ok && !pending[bus.iss_addr];
    assign dec = bus.wr_en && pending[bus.wr_addr]
                 && !(iss_ok && (bus.iss_addr == bus.wr_addr));

    always_comb begin
        cnt_nxt = cnt;
        if (bus.flush) begin
            cnt_nxt = '0;
        end else begin
            case ({inc, dec})
                2'b10:   cnt_nxt = cnt + (ADDR_W+1)'(1);
                2'b01:   cnt_nxt = cnt - (ADDR_W+1)'(1);
                default: cnt_nxt = cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            pending <= pend_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (bus.wr_en && !wr_zero) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end
endmodule
